poly_dl_arbiter: RTL and testbench
==================================

POLY_DL_ARBITER -- requirements
Module: poly_dl_arbiter

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 0, download index whose bytes are written to program RAM.
REQ-002 SHALL have parameter TNO_INDEX, default 1, download index whose bytes set the title number.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the download write buffer (power of 2, 2..16).
REQ-004 SHALL have parameter HOLD_CYCLES, default 256, number of cycles CPU reset is held after the buffer empties.
REQ-005 One clock; reset is asynchronous and active-low: clk_sys  in  1  system clock, all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 dn_download  in  1  high while the HPS transfer is active.
REQ-008 dn_wr  in  1  one-cycle download byte strobe; dn_addr  in  16  byte address; dn_data  in  8  byte; dn_index  in  8  download index.
REQ-009 cpu_req  in  1  CPU access request, held until cpu_ack; cpu_we  in  1  write when high; cpu_addr  in  16; cpu_din  in  8.
REQ-010 cpu_dout  out  8  read data, valid in the cpu_ack cycle; cpu_ack  out  1  one-cycle completion pulse.
REQ-011 ram_addr  out  16; ram_din  out  8; ram_we  out  1; ram_dout  in  8  synchronous read data, one cycle after address.
REQ-012 ram_stall  in  1  RAM port unavailable this cycle (video fetch); no access issued while high.
REQ-013 cpu_reset  out  1  holds the core in reset; tno  out  8  title number; dl_busy  out  1  high outside RUN; overflow  out  1  sticky dropped-byte flag.

Function
REQ-014 SHALL implement FSM states RUN, LOAD, DRAIN, HOLD.
REQ-015 RUN->LOAD when dn_download rises; LOAD->DRAIN when dn_download falls; DRAIN->HOLD when buffer empty and no RAM write in flight; HOLD->RUN after HOLD_CYCLES cycles; any state->LOAD on dn_download rising.
REQ-016 cpu_reset and dl_busy SHALL be 1 in LOAD, DRAIN, HOLD and 0 in RUN.
REQ-017 dn_wr with dn_index==ROM_INDEX SHALL push {dn_addr,dn_data} into the FIFO in any state.
REQ-018 Push when full SHALL drop the byte and set overflow; overflow clears only on reset or on LOAD entry.
REQ-019 Simultaneous push and pop on a full FIFO SHALL succeed (no drop).
REQ-020 dn_wr with dn_index==TNO_INDEX SHALL register tno<=dn_data next cycle; no FIFO push.
REQ-021 dn_wr with any other index SHALL be ignored.
REQ-022 Per cycle with ram_stall=0, exactly one RAM access: FIFO head write (priority) else pending CPU access (RUN only).
REQ-023 FIFO pop drives ram_addr/ram_din from head with ram_we=1 for that cycle.
REQ-024 CPU access issued in cycle N; cpu_ack=1 in cycle N+1; for reads cpu_dout=ram_dout in N+1.
REQ-025 At most one CPU access outstanding; cpu_req sampled high in the ack cycle SHALL not be issued until the following cycle.
REQ-026 ram_stall=1: ram_we=0, no pop, no CPU issue; requests wait unchanged.
REQ-027 CPU requests outside RUN SHALL not be issued nor acked; an access issued in the cycle before leaving RUN still acks.
REQ-028 HOLD counter SHALL be HOLD_CYCLES wide enough; restarts at 0 on each HOLD entry.

Reset
REQ-029 reset_n=0 SHALL force state RUN, FIFO empty, cpu_reset=0, dl_busy=0, cpu_ack=0, ram_we=0, cpu_dout=0, tno=0, overflow=0, hold counter=0.
REQ-030 Reset mid-download SHALL discard FIFO contents; no RAM write after reset release until a new push.

Verification
REQ-031 RUN, cpu_req read 0x1234, RAM holds 0x5A -> ram_addr=0x1234 cycle N, cpu_ack=1 and cpu_dout=0x5A cycle N+1.
REQ-032 Download index 0, 3 bytes to 0x0000..0x0002 -> three ram_we pulses in order, cpu_reset=1 from LOAD until 256 cycles after drain, then RUN.
REQ-033 ram_stall=1 for 10 cycles while 6 index-0 bytes arrive (depth 4) -> first 4 buffered, bytes 5-6 dropped, overflow=1, 4 writes after stall clears.
REQ-034 dn_wr index 1 data 0x07 -> tno=0x07 next cycle, no ram_we.
REQ-035 Download starts while cpu_req write issued -> that write acks once, no further CPU ack until RUN.
REQ-036 reset_n low with 3 FIFO entries -> all outputs at reset values, no ram_we after release.

Source files
------------

// File: rtl/poly_dl_arbiter.sv
// Download arbiter: buffers HPS download bytes into program RAM, shares the RAM
// port with CPU accesses, and holds the CPU in reset around a download.
module poly_dl_arbiter #(
  parameter int ROM_INDEX   = 0,
  parameter int TNO_INDEX   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [7:0]  dn_index,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  input  logic        ram_stall,
  output logic        cpu_reset,
  output logic [7:0]  tno,
  output logic        dl_busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {RUN, LOAD, DRAIN, HOLD} state_t;

  state_t        state_q, state_d;
  logic          dn_download_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   fifo_mem_q [FIFO_DEPTH];
  logic          overflow_q, overflow_d;
  logic [7:0]    tno_q, tno_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ack_q, ack_d;
  logic          rd_q, rd_d;

  logic        dl_rise, is_rom, is_tno;
  logic        fifo_full, fifo_empty;
  logic        push, pop, drop, issue;
  logic [23:0] head;

  always_comb begin
    dl_rise    = dn_download & ~dn_download_q;
    is_rom     = dn_wr && (dn_index == 8'(ROM_INDEX));
    is_tno     = dn_wr && (dn_index == 8'(TNO_INDEX)) && !is_rom;
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && !ram_stall;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push       = is_rom && (!fifo_full || pop);
    drop       = is_rom && fifo_full && !pop;
    issue      = (state_q == RUN) && cpu_req && !ack_q && !ram_stall && !pop;
    head       = fifo_mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    tno_d      = is_tno ? dn_data : tno_q;
    ack_d      = issue;
    rd_d       = issue && !cpu_we;
    overflow_d = dl_rise ? 1'b0 : overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: ;
      LOAD: begin
        if (!dn_download) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = RUN;
        else                                 hold_d  = hold_q + HW'(1);
      end
      default: state_d = RUN;
    endcase
    if (dl_rise) begin
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      dn_download_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      tno_q         <= 8'h00;
      hold_q        <= '0;
      ack_q         <= 1'b0;
      rd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      dn_download_q <= dn_download;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      tno_q         <= tno_d;
      hold_q        <= hold_d;
      ack_q         <= ack_d;
      rd_q          <= rd_d;
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {dn_addr, dn_data};
    end
  end

  always_comb begin
    ram_we    = pop | (issue & cpu_we);
    ram_addr  = pop ? head[23:8] : cpu_addr;
    ram_din   = pop ? head[7:0]  : cpu_din;
    cpu_ack   = ack_q;
    cpu_dout  = (ack_q && rd_q) ? ram_dout : 8'h00;
    cpu_reset = (state_q != RUN);
    dl_busy   = (state_q != RUN);
    tno       = tno_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_poly_dl_arbiter.sv
// Directed bench for poly_dl_arbiter with a behavioural synchronous RAM.
module tb_poly_dl_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dn_download, dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data, dn_index;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_we, ram_stall;
  logic        cpu_reset, dl_busy, overflow;
  logic [7:0]  tno;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram_mem [65536];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];

  always #5 clk = ~clk;

  poly_dl_arbiter #(
    .ROM_INDEX(0), .TNO_INDEX(1), .FIFO_DEPTH(4), .HOLD_CYCLES(256)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_index(dn_index),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .ram_stall(ram_stall),
    .cpu_reset(cpu_reset), .tno(tno), .dl_busy(dl_busy), .overflow(overflow)
  );

  // Synchronous RAM: read data one cycle after the address, read-before-write.
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      ram_mem[ram_addr] <= ram_din;
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_din);
      $display("ram write addr=%h data=%h", ram_addr, ram_din);
    end
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_run();
    int n = 0;
    while (cpu_reset === 1'b1 && n < 400) begin
      n++;
      step();
    end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL wait_run cpu_reset got=%b exp=0", cpu_reset); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dn_download = 0; dn_wr = 0; dn_addr = 0; dn_data = 0; dn_index = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; ram_stall = 0;
    step(); step();
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset got=%b exp=0", cpu_reset); end
    checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL rst_dl_busy got=%b exp=0", dl_busy); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got=%b exp=0", cpu_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL rst_cpu_dout got=%h exp=00", cpu_dout); end
    checks++; if (tno !== 8'h00) begin errors++; $display("FAIL rst_tno got=%h exp=00", tno); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    reset_n = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    #1;
    checks++; if (ram_addr !== 16'h1234) begin errors++; $display("FAIL rd_ram_addr got=%h exp=1234", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_ram_we got=%b exp=0", ram_we); end
    step();
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", cpu_ack); end
    checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL rd_dout got=%h exp=5a", cpu_dout); end
    cpu_req = 0;
    step();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_clear got=%b exp=0", cpu_ack); end
    $display("cpu read 1234 dout=%h", 8'h5A);
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_din = 8'h3C;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we got=%b exp=1", ram_we); end
    checks++; if (ram_din !== 8'h3C) begin errors++; $display("FAIL wr_ram_din got=%h exp=3c", ram_din); end
    step();
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", cpu_ack); end
    cpu_req = 0;
    step();
    cpu_req = 1; cpu_we = 0;
    step();
    checks++; if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL wr_readback got=%h exp=3c", cpu_dout); end
    cpu_req = 0;
    step();
    $display("cpu write 2000 data=3c");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    exp_ack = 4'b0101;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cpu_ack !== exp_ack[i]) begin errors++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, cpu_ack, exp_ack[i]); end
    end
    cpu_req = 0;
    step();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_end got=%b exp=0", cpu_ack); end
    $display("back-to-back reads done");
  endtask

  task automatic test_tno();
    clear_log();
    dn_wr = 1; dn_index = 8'd1; dn_data = 8'h07; dn_addr = 16'h0050;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL tno_ram_we got=%b exp=0", ram_we); end
    step();
    dn_wr = 0;
    checks++; if (tno !== 8'h07) begin errors++; $display("FAIL tno_value got=%h exp=07", tno); end
    dn_wr = 1; dn_index = 8'd5; dn_data = 8'h99;
    step();
    dn_wr = 0;
    step(); step();
    checks++; if (tno !== 8'h07) begin errors++; $display("FAIL tno_other_idx got=%h exp=07", tno); end
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL tno_no_writes got=%0d exp=0", log_addr.size()); end
    $display("tno set to 07");
  endtask

  task automatic test_download();
    int n = 0;
    clear_log();
    dn_download = 1;
    step();
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL dl_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (dl_busy !== 1'b1) begin errors++; $display("FAIL dl_busy got=%b exp=1", dl_busy); end
    for (int i = 0; i < 3; i++) begin
      dn_wr = 1; dn_index = 8'd0; dn_addr = 16'(i); dn_data = 8'hA0 + 8'(i);
      step();
    end
    dn_wr = 0; dn_download = 0;
    step();
    while (cpu_reset === 1'b1 && n < 400) begin
      n++;
      step();
    end
    checks++; if (n != 257) begin errors++; $display("FAIL dl_reset_len got=%0d exp=257", n); end
    checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL dl_busy_end got=%b exp=0", dl_busy); end
    checks++; if (log_addr.size() != 3) begin errors++; $display("FAIL dl_write_count got=%0d exp=3", log_addr.size()); end
    if (log_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (log_addr[i] !== 16'(i) || log_data[i] !== 8'hA0 + 8'(i)) begin
          errors++; $display("FAIL dl_write%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], 16'(i), 8'hA0 + 8'(i));
        end
      end
    end
    $display("download of 3 bytes, reset held %0d cycles", n);
  endtask

  task automatic test_overflow();
    clear_log();
    dn_download = 1;
    step();
    ram_stall = 1;
    for (int i = 0; i < 6; i++) begin
      dn_wr = 1; dn_index = 8'd0; dn_addr = 16'h0100 + 16'(i); dn_data = 8'h10 + 8'(i);
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ovf_stall_we%0d got=%b exp=0", i, ram_we); end
      step();
    end
    dn_wr = 0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL ovf_stalled_writes got=%0d exp=0", log_addr.size()); end
    ram_stall = 0; dn_download = 0;
    wait_run();
    checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL ovf_write_count got=%0d exp=4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (log_addr[i] !== 16'h0100 + 16'(i) || log_data[i] !== 8'h10 + 8'(i)) begin
          errors++; $display("FAIL ovf_write%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], 16'h0100 + 16'(i), 8'h10 + 8'(i));
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    $display("overflow download: 6 pushed, 4 written");
  endtask

  task automatic test_full_push_pop();
    clear_log();
    dn_download = 1;
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_clear got=%b exp=0", overflow); end
    ram_stall = 1;
    for (int i = 0; i < 4; i++) begin
      dn_wr = 1; dn_index = 8'd0; dn_addr = 16'h0200 + 16'(i); dn_data = 8'h20 + 8'(i);
      step();
    end
    ram_stall = 0;
    dn_addr = 16'h0204; dn_data = 8'h24;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h0200) begin errors++; $display("FAIL fpp_pop got=%b/%h exp=1/0200", ram_we, ram_addr); end
    step();
    dn_wr = 0; dn_download = 0;
    wait_run();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_drop got=%b exp=0", overflow); end
    checks++; if (log_addr.size() != 5) begin errors++; $display("FAIL fpp_write_count got=%0d exp=5", log_addr.size()); end
    if (log_addr.size() == 5) begin
      checks++; if (log_addr[4] !== 16'h0204 || log_data[4] !== 8'h24) begin errors++; $display("FAIL fpp_last got=%h/%h exp=0204/24", log_addr[4], log_data[4]); end
    end
    $display("full push+pop download: 5 written");
  endtask

  task automatic test_cpu_during_download();
    int acks = 0;
    int n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_din = 8'h77;
    dn_download = 1;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h3000) begin errors++; $display("FAIL cdl_issue got=%b/%h exp=1/3000", ram_we, ram_addr); end
    step();
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cdl_ack got=%b exp=1", cpu_ack); end
    checks++; if (dl_busy !== 1'b1) begin errors++; $display("FAIL cdl_busy got=%b exp=1", dl_busy); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (cpu_ack === 1'b1) acks++;
    end
    dn_download = 0;
    while (cpu_reset === 1'b1 && n < 400) begin
      n++;
      step();
      if (cpu_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL cdl_extra_acks got=%0d exp=0", acks); end
    step();
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cdl_run_ack got=%b exp=1", cpu_ack); end
    cpu_req = 0;
    checks++; if (ram_mem[16'h3000] !== 8'h77) begin errors++; $display("FAIL cdl_ram got=%h exp=77", ram_mem[16'h3000]); end
    step();
    $display("cpu write during download acked once before LOAD");
  endtask

  task automatic test_reset_midload();
    dn_download = 1;
    step();
    ram_stall = 1;
    for (int i = 0; i < 3; i++) begin
      dn_wr = 1; dn_index = 8'd0; dn_addr = 16'h0400 + 16'(i); dn_data = 8'h40 + 8'(i);
      step();
    end
    dn_wr = 0;
    reset_n = 0; ram_stall = 0; dn_download = 0;
    #1;
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rml_cpu_reset got=%b exp=0", cpu_reset); end
    checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL rml_dl_busy got=%b exp=0", dl_busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rml_ram_we got=%b exp=0", ram_we); end
    checks++; if (cpu_ack !== 1'b0 || cpu_dout !== 8'h00) begin errors++; $display("FAIL rml_cpu got=%b/%h exp=0/00", cpu_ack, cpu_dout); end
    checks++; if (tno !== 8'h00) begin errors++; $display("FAIL rml_tno got=%h exp=00", tno); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rml_overflow got=%b exp=0", overflow); end
    step(); step();
    reset_n = 1;
    clear_log();
    for (int i = 0; i < 5; i++) step();
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL rml_writes got=%0d exp=0", log_addr.size()); end
    $display("reset mid-download discarded buffered bytes");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
    ram_mem[16'h1234] = 8'h5A;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back();
    test_tno();
    test_download();
    test_overflow();
    test_full_push_pop();
    test_cpu_during_download();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
